// File: rtl/fft_seq.sv
// Frame sequencer for a streaming FFT datapath: paces N-sample frames, drives the
// shared slot counter, and delays slot markers by the datapath latency.
module fft_seq #(
    parameter int CBW = 3,
    parameter int LAT = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [CBW-1:0] cnt,
    output logic           out_valid,
    output logic           out_first,
    output logic           out_last,
    output logic           busy,
    output logic           done,
    output logic           err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CBW-1:0] CNT_ZERO = {CBW{1'b0}};
    localparam logic [CBW-1:0] CNT_ONE  = {{(CBW-1){1'b0}}, 1'b1};
    localparam logic [CBW-1:0] CNT_LAST = {CBW{1'b1}};

    state_t         state_r;
    state_t         state_nxt_s;
    logic [CBW-1:0] cnt_r;
    logic [CBW-1:0] cnt_nxt_s;
    logic           err_r;
    logic           err_nxt_s;
    logic           active_s;
    logic           ready_s;
    logic           done_s;
    logic [LAT-1:0] dv_r;
    logic [LAT-1:0] df_r;
    logic [LAT-1:0] dl_r;

    // Control state, slot counter and sticky gap flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Next-state logic; the counter free-runs outside IDLE so the stream never stalls.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + CNT_ONE;
        err_nxt_s   = err_r;
        active_s    = 1'b0;
        ready_s     = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                ready_s = en;
                if (en && in_valid) begin
                    active_s    = 1'b1;
                    state_nxt_s = RUN;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            RUN: begin
                if (cnt_r == CNT_ZERO) begin
                    // Frame boundary: only here can en stop the stream.
                    ready_s = en;
                    if (en && in_valid) begin
                        active_s    = 1'b1;
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end else begin
                    ready_s  = 1'b1;
                    active_s = 1'b1;
                    if (!in_valid) begin
                        err_nxt_s = 1'b1;
                    end else begin
                        err_nxt_s = err_r;
                    end
                end
            end
            DRAIN: begin
                if (cnt_r == CNT_LAST) begin
                    done_s      = 1'b1;
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Slot markers travel alongside the datapath; stage LAT-1 lines up with its result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_r <= {LAT{1'b0}};
            df_r <= {LAT{1'b0}};
            dl_r <= {LAT{1'b0}};
        end else begin
            dv_r[0] <= active_s;
            df_r[0] <= (cnt_r == CNT_ZERO);
            dl_r[0] <= (cnt_r == CNT_LAST);
            for (int i = 1; i < LAT; i++) begin
                dv_r[i] <= dv_r[i-1];
                df_r[i] <= df_r[i-1];
                dl_r[i] <= dl_r[i-1];
            end
        end
    end

    assign in_ready  = ready_s;
    assign cnt       = cnt_r;
    assign out_valid = dv_r[LAT-1];
    assign out_first = dv_r[LAT-1] & df_r[LAT-1];
    assign out_last  = dv_r[LAT-1] & dl_r[LAT-1];
    assign busy      = (state_r != IDLE);
    assign done      = done_s;
    assign err       = err_r;

endmodule

// File: doc/fft_seq.md
FFT_SEQ -- requirements
Module: fft_seq

Interface
REQ-001 Parameter CBW, default 3: frame counter width; frame length N = 2^CBW samples, CBW >= 2.
REQ-002 Parameter LAT, default 5: datapath latency in cycles from sample slot to result, 1 <= LAT <= N.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  enable; gates new frame acceptance.
REQ-006 in_valid  input  1  upstream sample present.
REQ-007 in_ready  output  1  block accepts a sample this cycle.
REQ-008 cnt  output  CBW  sample-slot counter driven to all datapath stages (halfrate, butterflies).
REQ-009 out_valid  output  1  datapath result valid, delayed LAT cycles from its slot.
REQ-010 out_first  output  1  result belongs to slot cnt==0.
REQ-011 out_last  output  1  result belongs to slot cnt==N-1.
REQ-012 busy  output  1  state != IDLE.
REQ-013 done  output  1  one-cycle pulse at end of drain.
REQ-014 err  output  1  sticky mid-frame gap flag.

Function
REQ-015 States: IDLE, RUN, DRAIN; state, cnt, delay line and err are registers.
REQ-016 IDLE: cnt = 0; in_ready = en; if en && in_valid, slot 0 is accepted this cycle and next state = RUN with cnt = 1.
REQ-017 RUN: cnt increments by 1 every cycle unconditionally, wrapping N-1 -> 0; the stream never stalls.
REQ-018 RUN, cnt != 0: in_ready = 1; in_valid = 0 sets err (sticky), slot still counted as active, cnt still advances.
REQ-019 RUN, cnt == 0: in_ready = en; if en && in_valid, new back-to-back frame continues in RUN; else slot is inactive and next state = DRAIN (cnt -> 1).
REQ-020 DRAIN: in_ready = 0; cnt keeps incrementing; at cnt == N-1 next state = IDLE, cnt -> 0, done = 1 in that cycle.
REQ-021 Drain length is exactly N cycles counted from the inactive cnt==0 RUN cycle, so all pipeline results (LAT <= N) emerge before IDLE.
REQ-022 Slot active = (IDLE accept) or (RUN and not the inactive cnt==0 cycle of REQ-019).
REQ-023 Delay line: LAT-deep shift of {active, cnt==0, cnt==N-1}; outputs out_valid, out_first && active, out_last && active from the last stage.
REQ-024 out_first/out_last never asserted without out_valid.
REQ-025 en deassertion mid-frame does not stop the frame; it only forces DRAIN at the next cnt==0.
REQ-026 in_valid in DRAIN is ignored, no err.
REQ-027 busy = (state != IDLE); done combinational from state and cnt, high only one cycle per drain.

Reset
REQ-028 rst asserted (any time, incl. mid-frame): state = IDLE, cnt = 0, delay line cleared, err = 0; outputs in_ready = en, out_valid = out_first = out_last = busy = done = 0.
REQ-029 First frame after rst release accepted on the first rising edge with en && in_valid.

Verification (CBW=3, LAT=5, frame starts cycle t0)
REQ-030 Single frame: en=1, in_valid=1 t0..t0+7 -> cnt 0..7 at t0..t0+7; out_valid t0+5..t0+12; out_first t0+5; out_last t0+12; DRAIN t0+9..t0+15; done t0+15; IDLE/busy=0 at t0+16; err=0.
REQ-031 Back-to-back: in_valid=1 t0..t0+15 -> cnt wraps 7->0 at t0+8 in RUN; out_valid continuous t0+5..t0+20; out_first t0+5, t0+13; out_last t0+12, t0+20; done t0+23.
REQ-032 Gap: in_valid=0 at t0+3 only -> err=1 from t0+4 and stays; cnt sequence unchanged; out_valid still t0+5..t0+12.
REQ-033 en drop: en=0 from t0+2, in_valid held high -> frame completes, DRAIN entered at t0+9, in_ready=0 t0+8..t0+15, no second frame accepted.
REQ-034 Reset mid-frame: rst pulsed at t0+4 -> cnt=0, IDLE, out_valid=0, err=0 immediately; no out_valid afterwards until a new frame; new frame accepted on first edge after release.
